// File: rtl/am_envelope_decimator.sv
// ---------------------------------------------------------------------------
// am_envelope_decimator
//
// Purpose:
//   Envelope front end for the AM demodulator. Takes channel A offset-binary
//   ADC samples, converts them to signed, full-wave rectifies them and sums
//   |x| over a programmable block of N samples (boxcar integrate-and-dump).
//   Each finished block sum is queued in a small show-ahead FIFO that is
//   read through a valid/ready handshake.
//
// Optional feature:
//   AM_ENV_DC_REMOVE_EN - when defined, a first-order IIR DC tracker
//   (time constant 2^DC_SHIFT samples) is subtracted from each sample
//   before rectification. When undefined, the tracker is not built at all.
//
// Ports:
//   main_clk      in   single clock, rising edge
//   rstn          in   asynchronous active-low reset
//   in_data       in   8-bit ADC sample, offset binary (0x80 = mid-scale)
//   in_valid      in   in_data qualifier, no backpressure
//   clear         in   synchronous flush of all datapath/FIFO/counter state
//   decim_ratio   in   block length N (0 behaves as 1)
//   out_data      out  FIFO head, sum of |x| over one block
//   out_valid     out  FIFO not empty
//   out_ready     in   consumer accept, pops when out_valid && out_ready
//   fifo_level    out  FIFO occupancy
//   overflow_cnt  out  count of dropped block sums, saturates at 255
// ---------------------------------------------------------------------------
module am_envelope_decimator #(
    parameter int ACC_W      = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int DC_SHIFT   = 8
) (
    input  logic                          main_clk,
    input  logic                          rstn,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          clear,
    input  logic [11:0]                   decim_ratio,
    output logic [ACC_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Offset binary to two's complement is just an MSB flip.
    logic signed [7:0] w_s;
    logic [8:0]        w_rect;

    assign w_s = {~in_data[7], in_data[6:0]};

`ifdef AM_ENV_DC_REMOVE_EN
    localparam int DC_W = 8 + DC_SHIFT;

    logic signed [DC_W-1:0] r_dc_acc;
    logic signed [7:0]      w_dc;
    logic signed [8:0]      w_diff;
    logic signed [7:0]      w_sat;

    // The tracker holds DC scaled by 2^DC_SHIFT; the arithmetic shift gives
    // the current DC estimate (floor), which always fits in 8 signed bits.
    assign w_dc   = r_dc_acc[DC_SHIFT +: 8];
    assign w_diff = {w_s[7], w_s} - {w_dc[7], w_dc};

    // Clamp the DC-corrected sample back into 8 signed bits.
    always_comb begin
        w_sat = w_diff[7:0];
        if (w_diff > 9'sd127) begin
            w_sat = 8'sd127;
        end else if (w_diff < -9'sd128) begin
            w_sat = -8'sd128;
        end
    end

    // Magnitude is 9 bits wide so that -128 rectifies to +128.
    assign w_rect = w_sat[7] ? (9'd0 - {1'b1, w_sat}) : {1'b0, w_sat};

    // Leaky integrator: dc_acc += s - dc, using the pre-update dc.
    always_ff @(posedge main_clk or negedge rstn) begin
        if (!rstn) begin
            r_dc_acc <= '0;
        end else if (clear) begin
            r_dc_acc <= '0;
        end else if (in_valid) begin
            r_dc_acc <= r_dc_acc + {{DC_SHIFT{w_s[7]}}, w_s}
                                 - {{DC_SHIFT{w_dc[7]}}, w_dc};
        end
    end
`else
    assign w_rect = w_s[7] ? (9'd0 - {1'b1, w_s}) : {1'b0, w_s};
`endif

    // Stage 1: register the rectified sample.
    logic       r_s1_valid;
    logic [8:0] r_s1_rect;

    always_ff @(posedge main_clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_rect  <= '0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
            r_s1_rect  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_rect <= w_rect;
            end
        end
    end

    // Stage 2: integrate-and-dump. The block length is captured on the first
    // sample of a block so that mid-block decim_ratio changes wait for the
    // next block.
    logic [ACC_W-1:0] r_acc;
    logic [11:0]      r_count;
    logic [11:0]      r_decim_q;
    logic [11:0]      w_decim_eff;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;
    logic             w_push;

    assign w_decim_eff = (r_count == 12'd0)
                       ? ((decim_ratio == 12'd0) ? 12'd1 : decim_ratio)
                       : r_decim_q;
    assign w_last      = (r_count == (w_decim_eff - 12'd1));
    assign w_sum       = r_acc + ACC_W'(r_s1_rect);
    assign w_push      = r_s1_valid && w_last;

    always_ff @(posedge main_clk or negedge rstn) begin
        if (!rstn) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_decim_q <= 12'd1;
        end else if (clear) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_decim_q <= 12'd1;
        end else if (r_s1_valid) begin
            if (r_count == 12'd0) begin
                r_decim_q <= w_decim_eff;
            end
            if (w_last) begin
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + 12'd1;
            end
        end
    end

    // Output FIFO. A push into a full FIFO only succeeds if a pop happens in
    // the same cycle; otherwise the block sum is dropped and counted.
    logic [ACC_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [7:0]       r_ovf;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic             w_drop;

    assign w_pop  = (r_level != '0) && out_ready;
    assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge main_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= '0;
        end else if (clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_sum;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
        end
    end

    assign out_data     = r_mem[r_rd_ptr];
    assign out_valid    = (r_level != '0);
    assign fifo_level   = r_level;
    assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_am_envelope_decimator.sv
// ---------------------------------------------------------------------------
// tb_am_envelope_decimator
//
// Purpose:
//   Self-checking bench for am_envelope_decimator. A sample-level reference
//   model (block sums as integers, the FIFO as a queue) predicts the outputs
//   every cycle; directed sequences add explicit expected constants.
//   Builds with or without AM_ENV_DC_REMOVE_EN.
// ---------------------------------------------------------------------------
module tb_am_envelope_decimator;

    localparam int ACC_W = 20;
    localparam int DEPTH = 4;
    localparam int SH    = 4;

    logic              main_clk;
    logic              rstn;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              clear;
    logic [11:0]       decim_ratio;
    logic [ACC_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        fifo_level;
    logic [7:0]        overflow_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    int mq[$];
    int mOvf;
    int mBlkSum;
    int mBlkCount;
    int mBlkLen;
    bit mS1Valid;
    int mS1Rect;
    int mDcAcc;

    am_envelope_decimator #(
        .ACC_W(ACC_W),
        .FIFO_DEPTH(DEPTH),
        .DC_SHIFT(SH)
    ) dut (
        .main_clk(main_clk),
        .rstn(rstn),
        .in_data(in_data),
        .in_valid(in_valid),
        .clear(clear),
        .decim_ratio(decim_ratio),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fifo_level(fifo_level),
        .overflow_cnt(overflow_cnt)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mOvf      = 0;
        mBlkSum   = 0;
        mBlkCount = 0;
        mBlkLen   = 1;
        mS1Valid  = 0;
        mS1Rect   = 0;
        mDcAcc    = 0;
    endtask

    // |x| of one sample; offset binary means signed value = code - 128.
    function automatic int rectOf(input logic [7:0] d);
        int s;
        int y;
`ifdef AM_ENV_DC_REMOVE_EN
        int dc;
`endif
        s = int'(d) - 128;
`ifdef AM_ENV_DC_REMOVE_EN
        dc = mDcAcc >>> SH;
        y  = s - dc;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        mDcAcc = mDcAcc + s - dc;
`else
        y = s;
`endif
        return (y < 0) ? -y : y;
    endfunction

    // One rising edge of the reference: a sample is rectified on the edge
    // that takes it, added to its block on the next edge, and a finished
    // block lands in the FIFO on that same second edge.
    task automatic modelEdge(input logic v, input logic [7:0] d, input logic r, input logic clr);
        bit push;
        int sum;
        if (clr) begin
            modelReset();
        end else begin
            push = 0;
            sum  = 0;
            if (mS1Valid) begin
                if (mBlkCount == 0) mBlkLen = (decim_ratio == 0) ? 1 : int'(decim_ratio);
                mBlkSum   += mS1Rect;
                mBlkCount += 1;
                if (mBlkCount == mBlkLen) begin
                    push      = 1;
                    sum       = mBlkSum;
                    mBlkSum   = 0;
                    mBlkCount = 0;
                end
            end
            if ((mq.size() > 0) && r) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(sum);
                else if (mOvf < 255) mOvf++;
            end
            mS1Valid = v;
            if (v) mS1Rect = rectOf(d);
        end
    endtask

    task automatic checkOutput();
        checkVal("out_valid", out_valid, mq.size() > 0);
        checkVal("fifo_level", fifo_level, mq.size());
        checkVal("overflow_cnt", overflow_cnt, mOvf);
        if (mq.size() > 0) checkVal("out_data", out_data, mq[0]);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = clr;
        @(posedge main_clk);
        modelEdge(v, d, r, clr);
        #1;
        checkOutput();
    endtask

    initial begin
        int words;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        clear       = 1'b0;
        out_ready   = 1'b0;
        decim_ratio = 12'd4;
        rstn        = 1'b0;
        modelReset();
        #3;
        checkVal("rst_out_data", out_data, 0);
        checkOutput();
        #9 rstn = 1'b1;

        // Directed: one block of four mixed samples, sum 127+128+0+16
        decim_ratio = 12'd4;
        applyStimulus(1, 8'hFF, 0, 0);
        applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(1, 8'h80, 0, 0);
        applyStimulus(1, 8'h90, 0, 0);
        checkVal("t1_not_yet_valid", out_valid, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t1_valid", out_valid, 1);
        checkVal("t1_word", out_data, 271);
        applyStimulus(0, 8'h00, 1, 0);
        checkVal("t1_drained", out_valid, 0);

        // Directed: N=1, no reader, seven samples overflow a depth-4 FIFO
        applyStimulus(0, 8'h00, 0, 1);
        decim_ratio = 12'd1;
        for (int i = 0; i < 7; i++) applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t2_level", fifo_level, 4);
        checkVal("t2_ovf", overflow_cnt, 3);
        for (int i = 0; i < 4; i++) begin
            checkVal("t2_word", out_data, 128);
            applyStimulus(0, 8'h00, 1, 0);
        end
        checkVal("t2_empty", out_valid, 0);

        // Directed: full FIFO, pop in the same cycle as a push
        applyStimulus(0, 8'h00, 0, 1);
        decim_ratio = 12'd4;
        for (int i = 0; i < 16; i++) applyStimulus(1, 8'h10, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t3_full", fifo_level, 4);
        checkVal("t3_word", out_data, 448);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h10, 0, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkVal("t3_level_kept", fifo_level, 4);
        checkVal("t3_no_drop", overflow_cnt, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h10, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t3_drop", overflow_cnt, 1);

        // Directed: decim_ratio change mid-block, then ratio 0
        applyStimulus(0, 8'h00, 0, 1);
        decim_ratio = 12'd4;
        applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(1, 8'h00, 0, 0);
        decim_ratio = 12'd2;
        for (int i = 0; i < 6; i++) applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t4_level", fifo_level, 3);
        checkVal("t4_word0", out_data, 512);
        applyStimulus(0, 8'h00, 1, 0);
        checkVal("t4_word1", out_data, 256);
        applyStimulus(0, 8'h00, 1, 0);
        checkVal("t4_word2", out_data, 256);
        applyStimulus(0, 8'h00, 1, 0);
        decim_ratio = 12'd0;
        applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t4_ratio0_level", fifo_level, 2);
        checkVal("t4_ratio0_word", out_data, 128);

        // Directed: asynchronous reset mid-block, then clear mid-block
        applyStimulus(0, 8'h00, 0, 1);
        decim_ratio = 12'd1;
        for (int i = 0; i < 6; i++) applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        decim_ratio = 12'd4;
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h00, 0, 0);
        #2 rstn = 1'b0;
        #1;
        modelReset();
        checkVal("t5_rst_valid", out_valid, 0);
        checkVal("t5_rst_level", fifo_level, 0);
        checkVal("t5_rst_ovf", overflow_cnt, 0);
        checkVal("t5_rst_data", out_data, 0);
        #2 rstn = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t5_after_rst_level", fifo_level, 1);
        checkVal("t5_after_rst_word", out_data, 512);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        checkVal("t5_clear_level", fifo_level, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkVal("t5_after_clr_level", fifo_level, 1);
        checkVal("t5_after_clr_word", out_data, 512);

        // Directed: constant input, N=16, continuous reader
        applyStimulus(0, 8'h00, 0, 1);
        decim_ratio = 12'd16;
        words = 0;
        for (int i = 0; i < 480; i++) begin
            applyStimulus(1, 8'hA0, 1, 0);
            if (mq.size() > 0) begin
`ifdef AM_ENV_DC_REMOVE_EN
                if (words == 0) checkVal("t6_first_large", out_data > 256, 1);
                if (words >= 25) checkVal("t6_settled_small", out_data <= 16, 1);
`else
                checkVal("t6_word", out_data, 512);
`endif
                words++;
            end
        end
        checkVal("t6_word_count", words, 29);

        // Randomized traffic against the model
        applyStimulus(0, 8'h00, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            if ((i % 97) == 0) begin
                case ($urandom_range(0, 5))
                    0: decim_ratio = 12'd0;
                    1: decim_ratio = 12'd1;
                    2: decim_ratio = 12'd2;
                    3: decim_ratio = 12'd3;
                    4: decim_ratio = 12'd5;
                    default: decim_ratio = 12'd9;
                endcase
            end
            applyStimulus($urandom_range(0, 3) != 0,
                          8'($urandom_range(0, 255)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
